// File: rtl/reg_file_dump_pkg.sv
// ============================================================================
// Module : reg_file_dump_pkg
// Brief  : Shared constants and state encoding for the register-file dump engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package reg_file_dump_pkg;

    localparam int          DUMP_ADDR_W  = 5;
    localparam int          DUMP_DATA_W  = 32;
    localparam int          DUMP_STATE_W = 2;
    localparam logic [31:0] WORD_ZERO    = 32'h0000_0000;

    typedef enum logic [DUMP_STATE_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_SEND  = 2'b10,
        ST_DONE  = 2'b11
    } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_dump_if.sv
// ============================================================================
// Module : reg_file_dump_if
// Brief  : Control, register-file read port and output stream of the dump engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface reg_file_dump_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();
    logic              start;
    logic [ADDR_W-1:0] first_reg;
    logic [ADDR_W-1:0] last_reg;
    logic [ADDR_W-1:0] read_reg;
    logic [DATA_W-1:0] read_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_reg;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, first_reg, last_reg, read_data, out_ready,
        output read_reg, out_valid, out_reg, out_data, out_last, busy, done
    );

    modport slave (
        output start, first_reg, last_reg, read_data, out_ready,
        input  read_reg, out_valid, out_reg, out_data, out_last, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/reg_file_dump.sv
// ============================================================================
// Module : reg_file_dump
// Brief  : Walks a register range through one read port and streams each word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_dump
    import reg_file_dump_pkg::*;
#(
    parameter int ADDR_W  = DUMP_ADDR_W,
    parameter int DATA_W  = DUMP_DATA_W,
    parameter bit ZERO_R0 = 1'b0
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    reg_file_dump_if.master dump
);

    dump_state_t       r_state,     w_state_nxt;
    logic [ADDR_W-1:0] r_cur,       w_cur_nxt;
    logic [ADDR_W-1:0] r_end,       w_end_nxt;
    logic [ADDR_W-1:0] r_read_reg,  w_read_reg_nxt;
    logic [ADDR_W-1:0] r_out_reg,   w_out_reg_nxt;
    logic [DATA_W-1:0] r_out_data,  w_out_data_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic              r_out_last,  w_out_last_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_done,      w_done_nxt;

    logic [DATA_W-1:0] w_capture;
    logic              w_hs;

    assign w_capture = (ZERO_R0 && (r_cur == '0)) ? DATA_W'(WORD_ZERO) : dump.read_data;
    assign w_hs      = r_out_valid && dump.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cur       <= '0;
            r_end       <= '0;
            r_read_reg  <= '0;
            r_out_reg   <= '0;
            r_out_data  <= DATA_W'(WORD_ZERO);
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur       <= w_cur_nxt;
            r_end       <= w_end_nxt;
            r_read_reg  <= w_read_reg_nxt;
            r_out_reg   <= w_out_reg_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_nxt       = r_cur;
        w_end_nxt       = r_end;
        w_read_reg_nxt  = r_read_reg;
        w_out_reg_nxt   = r_out_reg;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (dump.start) begin
                    w_cur_nxt      = dump.first_reg;
                    w_end_nxt      = dump.last_reg;
                    w_read_reg_nxt = dump.first_reg;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = ST_ISSUE;
                end
            end
            // read_reg has been stable a full cycle; the file output is settled
            ST_ISSUE: begin
                w_out_data_nxt  = w_capture;
                w_out_reg_nxt   = r_cur;
                w_out_valid_nxt = 1'b1;
                w_out_last_nxt  = (r_cur == r_end);
                w_state_nxt     = ST_SEND;
            end
            ST_SEND: begin
                if (w_hs) begin
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                    if (r_cur == r_end) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cur_nxt      = r_cur + ADDR_W'(1);
                        w_read_reg_nxt = r_cur + ADDR_W'(1);
                        w_state_nxt    = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign dump.read_reg  = r_read_reg;
    assign dump.out_reg   = r_out_reg;
    assign dump.out_data  = r_out_data;
    assign dump.out_valid = r_out_valid;
    assign dump.out_last  = r_out_last;
    assign dump.busy      = r_busy;
    assign dump.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_dump.sv
// ============================================================================
// Module : tb_reg_file_dump
// Brief  : Two dump engines (ZERO_R0 = 0 / 1) on one modelled register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_dump;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic        out_ready;
    logic [31:0] regs [32];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_file_dump_if #(.ADDR_W(5), .DATA_W(32)) if0 ();
    reg_file_dump_if #(.ADDR_W(5), .DATA_W(32)) if1 ();

    assign if0.start     = start;
    assign if0.first_reg = first_reg;
    assign if0.last_reg  = last_reg;
    assign if0.out_ready = out_ready;
    assign if0.read_data = regs[if0.read_reg];
    assign if1.start     = start;
    assign if1.first_reg = first_reg;
    assign if1.last_reg  = last_reg;
    assign if1.out_ready = out_ready;
    assign if1.read_data = regs[if1.read_reg];

    reg_file_dump #(.ADDR_W(5), .DATA_W(32), .ZERO_R0(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .dump  (if0)
    );

    reg_file_dump #(.ADDR_W(5), .DATA_W(32), .ZERO_R0(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .dump  (if1)
    );

    logic        m_valid [2];
    logic [4:0]  m_reg   [2];
    logic [31:0] m_data  [2];
    logic        m_last  [2];
    logic        m_busy  [2];
    logic        m_done  [2];
    assign m_valid[0] = if0.out_valid; assign m_valid[1] = if1.out_valid;
    assign m_reg[0]   = if0.out_reg;   assign m_reg[1]   = if1.out_reg;
    assign m_data[0]  = if0.out_data;  assign m_data[1]  = if1.out_data;
    assign m_last[0]  = if0.out_last;  assign m_last[1]  = if1.out_last;
    assign m_busy[0]  = if0.busy;      assign m_busy[1]  = if1.busy;
    assign m_done[0]  = if0.done;      assign m_done[1]  = if1.done;

    // Model state: words still owed per DUT, scan-in-progress and done-due flags
    word_t       exp_q   [2][$];
    int          acc_idx [2][$];
    logic [31:0] acc_dat [2][$];
    bit          active   [2] = '{0, 0};
    bit          done_due [2] = '{0, 0};
    bit          p_hold   [2] = '{0, 0};
    logic [4:0]  p_reg    [2];
    logic [31:0] p_data   [2];
    logic        p_last   [2];

    int ready_mode = 0;
    int bp_cnt     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) p_hold[d] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (p_hold[d]) begin
                    chk("hold valid", m_valid[d], 1'b1);
                    chk("hold reg",   m_reg[d],   p_reg[d]);
                    chk("hold data",  m_data[d],  p_data[d]);
                    chk("hold last",  m_last[d],  p_last[d]);
                end
                chk("done", m_done[d], done_due[d]);
                chk("busy", m_busy[d], active[d]);
                if (done_due[d]) active[d] = 1'b0;
                done_due[d] = 1'b0;
                if (m_valid[d]) begin
                    if (exp_q[d].size() == 0) begin
                        chk("unexpected word", 1'b1, 1'b0);
                    end else begin
                        chk("word reg", m_reg[d], exp_q[d][0].idx);
                        if (out_ready) begin
                            word_t w;
                            w = exp_q[d].pop_front();
                            chk("word data", m_data[d], w.data);
                            chk("word last", m_last[d], exp_q[d].size() == 0);
                            acc_idx[d].push_back(int'(m_reg[d]));
                            acc_dat[d].push_back(m_data[d]);
                            if (exp_q[d].size() == 0) done_due[d] = 1'b1;
                        end
                    end
                end
                p_hold[d] = m_valid[d] && !out_ready;
                p_reg[d]  = m_reg[d];
                p_data[d] = m_data[d];
                p_last[d] = m_last[d];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom % 4) != 0;
            2: begin
                if (if0.out_valid && if0.out_reg == 5'd5 && bp_cnt < 5) begin
                    out_ready = 1'b0;
                    bp_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end
            default: out_ready = !(if0.out_valid && if0.out_reg == 5'd10);
        endcase
    endtask

    task automatic start_scan(input int f, input int l);
        int n;
        start     = 1'b1;
        first_reg = 5'(f);
        last_reg  = 5'(l);
        tick();
        start = 1'b0;
        n = ((l - f) % 32 + 32) % 32 + 1;
        for (int k = 0; k < n; k++) begin
            word_t w;
            w.idx  = 5'((f + k) % 32);
            w.data = regs[w.idx];
            exp_q[0].push_back(w);
            if (w.idx == 5'd0) w.data = 32'h0;
            exp_q[1].push_back(w);
        end
        active[0] = 1'b1;
        active[1] = 1'b1;
    endtask

    task automatic done_cycle(output int cnt);
        cnt = 1;
        while (!if0.done && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((active[0] || active[1]) && n < budget) begin
            tick();
            n++;
        end
        if (active[0] || active[1]) begin
            chk("scan timeout", 1'b1, 1'b0);
            for (int d = 0; d < 2; d++) begin
                exp_q[d].delete();
                active[d] = 1'b0;
            end
        end
    endtask

    task automatic clr_log();
        for (int d = 0; d < 2; d++) begin
            acc_idx[d].delete();
            acc_dat[d].delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int wrap_exp [4] = '{30, 31, 0, 1};
        int bp_exp   [3] = '{4, 5, 6};

        rst_n = 1'b0; start = 1'b0; first_reg = '0; last_reg = '0; out_ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst read_reg", if0.read_reg, 5'd0);
        chk("rst out_valid", if0.out_valid, 1'b0);
        chk("rst out_reg", if0.out_reg, 5'd0);
        chk("rst out_data", if0.out_data, 32'h0);
        chk("rst out_last", if0.out_last, 1'b0);
        chk("rst busy", if0.busy, 1'b0);
        chk("rst done", if0.done, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single word
        @(negedge clk); regs[1] = 32'h0000FFFF;
        tick(); clr_log();
        start_scan(1, 1);
        done_cycle(cnt);
        chk("single done cycle", cnt, 3);
        wait_idle(50);
        chk("single count", acc_idx[0].size(), 1);
        if (acc_idx[0].size() == 1) begin
            chk("single reg", acc_idx[0][0], 1);
            chk("single data", acc_dat[0][0], 32'h0000FFFF);
        end

        // Full dump
        @(negedge clk);
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
        tick(); clr_log();
        start_scan(0, 31);
        done_cycle(cnt);
        chk("full done cycle", cnt, 65);
        wait_idle(200);
        chk("full count", acc_idx[0].size(), 32);
        if (acc_idx[0].size() == 32) begin
            chk("full reg31", acc_idx[0][31], 31);
            chk("full data31", acc_dat[0][31], 32'd93);
        end

        // Wrap-around range
        @(negedge clk); regs[30] = 32'hFFFF0000;
        tick(); clr_log();
        start_scan(30, 1);
        wait_idle(100);
        chk("wrap count", acc_idx[0].size(), 4);
        if (acc_idx[0].size() == 4) begin
            for (int k = 0; k < 4; k++) chk("wrap order", acc_idx[0][k], wrap_exp[k]);
            chk("wrap data30", acc_dat[0][0], 32'hFFFF0000);
        end

        // Backpressure on the second word
        clr_log(); bp_cnt = 0; ready_mode = 2;
        start_scan(4, 6);
        wait_idle(100);
        ready_mode = 0;
        chk("bp stall cycles", bp_cnt, 5);
        chk("bp count", acc_idx[0].size(), 3);
        if (acc_idx[0].size() == 3)
            for (int k = 0; k < 3; k++) chk("bp order", acc_idx[0][k], bp_exp[k]);

        // Reset while holding reg 10 in SEND
        clr_log(); ready_mode = 3;
        start_scan(0, 31);
        cnt = 0;
        while (!(if0.out_valid && if0.out_reg == 5'd10) && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("reached reg10", if0.out_reg, 5'd10);
        tick(); tick();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            active[d]   = 1'b0;
            done_due[d] = 1'b0;
        end
        rst_n = 1'b1;
        ready_mode = 0; out_ready = 1'b1;
        chk("midrst valid", if0.out_valid, 1'b0);
        chk("midrst busy", if0.busy, 1'b0);
        chk("midrst read_reg", if0.read_reg, 5'd0);
        chk("midrst valid1", if1.out_valid, 1'b0);
        tick(); clr_log();
        start_scan(3, 3);
        wait_idle(50);
        chk("after rst count", acc_idx[0].size(), 1);
        if (acc_idx[0].size() == 1) chk("after rst reg", acc_idx[0][0], 3);

        // Start while busy is ignored; register 0 forced to zero on dut1
        @(negedge clk); regs[0] = 32'h12345678;
        tick(); clr_log();
        start_scan(0, 2);
        tick();
        start = 1'b1; first_reg = 5'd20; last_reg = 5'd25;
        tick(); tick(); tick();
        start = 1'b0;
        wait_idle(100);
        chk("busy start count0", acc_idx[0].size(), 3);
        chk("busy start count1", acc_idx[1].size(), 3);
        if (acc_dat[0].size() == 3 && acc_dat[1].size() == 3) begin
            chk("r0 raw", acc_dat[0][0], 32'h12345678);
            chk("r0 zeroed", acc_dat[1][0], 32'h0);
        end

        // Randomised scans against the model
        ready_mode = 1;
        for (int s = 0; s < 15; s++) begin
            @(negedge clk);
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            tick();
            start_scan(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            wait_idle(400);
            repeat ($urandom_range(0, 3)) tick();
        end
        ready_mode = 0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_file_dump.md
Name: reg_file_dump

Overview:
- Read-side scan engine for the 32x32 register file.
- On `start`, it walks a register address range through one register-file read port.
- Each captured word goes out on a valid/ready stream (register index + data). Used by the testbench/debug path to dump architectural state after a program run, without hierarchical peeking.
- Sits beside the datapath; drives one `read_reg` address input of the register file and consumes the matching `read_data`.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- ZERO_R0, 0, if 1 the word emitted for address 0 is forced to `WORD_ZERO regardless of file contents.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a scan (sampled only in IDLE).
- first_reg  input  ADDR_W  first register of the range (latched on start).
- last_reg  input  ADDR_W  last register of the range (latched on start).
- read_reg  output  ADDR_W  address driven to the register-file read port.
- read_data  input  DATA_W  combinational data returned by the register file.
- out_valid  output  1  stream word valid.
- out_ready  input  1  consumer accepts the word.
- out_reg  output  ADDR_W  index of the emitted register.
- out_data  output  DATA_W  value of the emitted register.
- out_last  output  1  marks the final word of the scan.
- busy  output  1  high from the cycle after start through DONE.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rst_n=0 at posedge, any state, including mid-scan): state=IDLE; read_reg, out_reg, cur, end = 0; out_data = `WORD_ZERO; out_valid, out_last, busy, done = 0. A partially sent scan is abandoned; no further words are emitted.
- States and transitions:
  - IDLE: on start=1, latch cur=first_reg and end=last_reg, drive read_reg=first_reg, busy=1, go to ISSUE.
  - ISSUE: read_reg=cur is held stable for one full cycle. At the next posedge: out_data = read_data (or `WORD_ZERO if ZERO_R0 and cur=0), out_reg=cur, out_valid=1, out_last=(cur==end); go to SEND.
  - SEND: out_valid, out_reg, out_data and out_last stay stable while out_ready=0.
  - SEND handshake (out_valid&&out_ready at posedge), cur==end: out_valid=0, go to DONE.
  - SEND handshake, otherwise: cur=cur+1 mod 2^ADDR_W, read_reg=cur+1, out_valid=0, go to ISSUE.
  - DONE: done=1 for exactly this cycle, busy=0 on exit, go to IDLE.
- Latency: first out_valid 2 cycles after the start edge. Minimum 2 cycles per word. A scan of N words with out_ready tied high takes 2N+1 cycles from the start edge to the done pulse.
- Range and wrap-around:
  - Word count N = ((last_reg - first_reg) mod 32) + 1.
  - first_reg == last_reg gives exactly 1 word.
  - last_reg < first_reg wraps 31 -> 0 (e.g. 30..1 gives 30, 31, 0, 1).
  - Full dump is first=0, last=31.
- start while busy or in DONE is ignored. first_reg/last_reg changes after the latch have no effect.
- Register file writes land on negedge clk. A write to `cur` during ISSUE is visible in the captured word. A write after capture is not reflected: the snapshot is per word, not atomic across the scan.
- Register 0 is not hardwired in the file; its stored value is emitted unless ZERO_R0=1.
- read_reg changes only on posedge, never combinationally from inputs.

Decomposition:
- State encodings (IDLE/ISSUE/SEND/DONE) and DUMP_STATE_W go in constant_values.vh, alongside the existing `WORD_ZERO.
- No sub-module. The FSM, address counter and output holding register form one module.

Test Plan:
- Reset then preload reg1=32'h0000FFFF; start with first=1, last=1, out_ready=1 -> one word out_reg=1, out_data=32'h0000FFFF, out_last=1; done pulses on cycle 3 after start.
- Full dump first=0, last=31, out_ready=1, file preloaded with reg[i]=i*3 -> 32 words in order 0..31, data i*3, out_last only on reg 31, done 65 cycles after start.
- Wrap first=30, last=1, reg30=32'hFFFF0000 -> order 30, 31, 0, 1; exactly 4 words; out_last on reg 1.
- Backpressure: out_ready low for 5 cycles on word 2 of a scan 4..6 -> out_valid/out_reg=5/out_data held constant throughout; scan resumes; no word dropped or duplicated.
- Reset mid-scan: rst_n=0 while in SEND on reg 10 of 0..31 -> next cycle out_valid=0, busy=0, read_reg=0; a new start with 3..3 emits only reg 3.
- start pulsed while busy; ZERO_R0=1 with reg0=32'h12345678 -> second start ignored, word count unchanged; reg0 emitted as 0.
